// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial shift transmitter.
// Optional parity cycle is enabled by defining SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } tx_state_e;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Bit counter width: must hold WIDTH without wrapping.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_shift_transmitter_load_register.sv
// WIDTH-wide rising-edge D register with enable and asynchronous active-high reset.
module load_register
   import serial_tx_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             E,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] word_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
      end else if (E) begin
         word_q <= D;
      end
   end

   assign Q = word_q;

endmodule

// File: rtl/serial_shift_transmitter.sv
// Parallel-in, serial-out transmitter, LSB first, with valid and end-of-word pulse.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_shift_transmitter
   import serial_tx_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
   input  logic             E,
   output logic             ready,
   output logic             Q,
   output logic             valid,
   output logic             done
);

   localparam int unsigned     CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   tx_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] cur;
   logic             load_en;

   assign load_en = E && ready;

   load_register #(.WIDTH(WIDTH)) u_load (
      .clk   (clk),
      .reset (reset),
      .E     (load_en),
      .D     (D),
      .Q     (word_q)
   );

   // The first data cycle reads the freshly captured word; from then on the
   // shift register holds the right-shifted copy, so it is cleared on load.
   assign cur = (cnt_q == '0) ? word_q : sr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      ready   = 1'b0;
      valid   = 1'b0;
      done    = 1'b0;
      Q       = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (E) begin
               cnt_d   = '0;
               sr_d    = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            valid = 1'b1;
            Q     = cur[0];
            sr_d  = cur >> 1;
`ifdef SERIAL_TX_PARITY_EN
            if (cnt_q == CW'(WIDTH)) begin
               Q       = ^word_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`else
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_shift_transmitter.sv
// Self-checking bench for serial_shift_transmitter (WIDTH=8), honours SERIAL_TX_PARITY_EN.
module tb_serial_shift_transmitter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] D;
   logic         E;
   logic         ready, Q, valid, done;

   int checks = 0;
   int errors = 0;

   always #4 clk = ~clk;

   serial_shift_transmitter #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .D     (D),
      .E     (E),
      .ready (ready),
      .Q     (Q),
      .valid (valid),
      .done  (done)
   );

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic r, input logic v, input logic q, input logic d);
      chk({tag, ".ready"}, {31'b0, ready}, {31'b0, r});
      chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
      chk({tag, ".Q"},     {31'b0, Q},     {31'b0, q});
      chk({tag, ".done"},  {31'b0, done},  {31'b0, d});
   endtask

   // Reference stream: data bits LSB first, then optional even parity.
   task automatic expected_stream(input logic [W-1:0] word, output logic s[$]);
      s = {};
      for (int i = 0; i < int'(W); i++) s.push_back(((word >> i) & 1) != 0);
`ifdef SERIAL_TX_PARITY_EN
      s.push_back(($countones(word) % 2) == 1);
`endif
   endtask

   // Called #1 after the load edge; returns at a negedge in the IDLE cycle.
   task automatic stream(input logic [W-1:0] word, input bit noisy);
      logic s[$];
      expected_stream(word, s);
      E = 1'b0;
      if (noisy) D = W'($urandom);
      foreach (s[i]) begin
         @(negedge clk);
         chk_out($sformatf("bit%0d", i), 1'b0, 1'b1, s[i], 1'b0);
         if (noisy) begin
            E = 1'($urandom);
            D = W'($urandom);
         end
      end
      @(negedge clk);
      chk_out("done_cycle", 1'b0, 1'b0, 1'b0, 1'b1);
      if (noisy) E = 1'($urandom);
      @(posedge clk);
      #1 E = 1'b0;
      @(negedge clk);
      chk_out("idle_after", 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs change a quarter period after a rising edge; outputs must not react.
   task automatic send(input logic [W-1:0] word, input bit noisy, input bit b2b);
      if (!b2b) begin
         @(posedge clk);
         #2;
      end
      D = word;
      E = 1'b1;
      #1 chk_out("pre_load", 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 stream(word, noisy);
   endtask

   initial begin
      logic [W-1:0] w;
      logic         s[$];

      reset = 1'b1;
      E     = 1'b0;
      D     = '0;
      #1 chk_out("reset_state", 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_out("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

      send(8'hA5, 1'b0, 1'b0);
      send(8'hFF, 1'b1, 1'b0);
      send(8'h3C, 1'b1, 1'b0);
      send(8'h07, 1'b0, 1'b0);
      send(8'hA5, 1'b1, 1'b0);

      // Back-to-back: load on the first edge where ready is high.
      send(8'h01, 1'b0, 1'b0);
      send(8'h80, 1'b0, 1'b1);

      // Mid-word reset, asserted between edges.
      D = 8'hA5;
      E = 1'b1;
      @(posedge clk);
      #1 E = 1'b0;
      expected_stream(8'hA5, s);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_out($sformatf("rst_bit%0d", i), 1'b0, 1'b1, s[i], 1'b0);
      end
      #1 reset = 1'b1;
      #1 chk_out("async_reset", 1'b1, 1'b0, 1'b0, 1'b0);
      E = 1'b1;
      D = 8'h5A;
      @(posedge clk);
      #1 chk_out("load_blocked_in_reset", 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 stream(8'h5A, 1'b0);

      for (int n = 0; n < 24; n++) begin
         w = W'($urandom);
         send(w, 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
